multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Control unit for the multi-cycle MIPS CPU; sequences each instruction through IF/ID/EXE/MEM/WB.
- Drives every datapath select and write enable, including ExtSel for the 16→32 immediate extender (sign vs zero extension).
- Sits beside the shared datapath: PC, IR, register file, ALU, extender and data memory.
- Instruction memory and data memory are single-ported, so each instruction takes 2–5 cycles.

Parameters:
- none (all encodings are constants in the package)

Ports:
- CLK  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26], valid from ID onward
- zero  in  1  ALU result == 0
- sign  in  1  ALU result[31]
- PCWre  out  1  PC write enable
- IRWre  out  1  IR load enable
- InsMemRW  out  1  instruction memory read, 1 = read
- ALUSrcA  out  1  0 = rs, 1 = sa (shift amount)
- ALUSrcB  out  1  0 = rt, 1 = extended immediate
- ExtSel  out  1  0 = zero-extend, 1 = sign-extend
- RegDst  out  2  00 = $31, 01 = rt, 10 = rd
- WrRegDSrc  out  1  0 = PC+4, 1 = ALU/memory result
- RegWre  out  1  register file write enable
- mRD  out  1  data memory read
- mWR  out  1  data memory write
- DBDataSrc  out  1  0 = ALU result, 1 = memory data
- PCSrc  out  2  00 = PC+4, 01 = branch target, 10 = rs, 11 = jump target
- ALUOp  out  3  000 ADD, 001 SUB, 010 SLT, 100 AND, 101 OR
- state  out  4  current state, for debug

Behaviour:
- Clocking and reset: one clock, CLK. Reset is synchronous and active-high. With Reset high at a CLK edge, state becomes IF.
- Outputs while Reset is high: PCWre, IRWre, RegWre and mWR are forced to 0. All other outputs are 0, except InsMemRW = 1.
- Reset mid-instruction: the instruction is abandoned; no partial writes occur after the reset edge.
- Opcodes: ADD 000000, SUB 000001, ADDIU 000010, AND 010000, ANDI 010001, ORI 010010, SLT 100110, SLTI 100111, SW 110000, LW 110001, BEQ 110100, BNE 110101, BLTZ 110110, J 111000, JR 111001, JAL 111010, HALT 111111.
- States: IF, ID, EXE_AL, EXE_BR, EXE_LS, MEM, WB_AL, WB_LD, HALT.
- Transitions:
  - IF → ID, always.
  - ID: J/JR/JAL → IF; HALT → HALT; branches → EXE_BR; LW/SW → EXE_LS; all others → EXE_AL.
  - EXE_AL → WB_AL → IF.
  - EXE_BR → IF.
  - EXE_LS → MEM.
  - MEM: LW → WB_LD → IF; SW → IF.
  - HALT: stays until Reset.
- Cycle counts: ALU instructions 4, LW 5, SW 4, branches 3, jumps 2.
- IF: IRWre = 1 and InsMemRW = 1; IR captures the instruction at the end of IF.
- PCWre = 1 only in the final cycle of each instruction: ID for jumps, EXE_BR, MEM for SW, WB_AL, WB_LD. It is never asserted in HALT.
- PCSrc:
  - BEQ & zero, BNE & !zero, BLTZ & sign → 01; otherwise 00.
  - J/JAL → 11; JR → 10.
  - zero and sign are sampled combinationally in EXE_BR.
- ExtSel = 1 for ADDIU, SLTI, LW, SW, BEQ, BNE, BLTZ. ExtSel = 0 for ANDI and ORI.
- ExtSel, ALUSrcB and ALUOp are held stable from ID through the instruction's last cycle.
- ALUOp by instruction: ADD/ADDIU/LW/SW → ADD; SUB/BEQ/BNE/BLTZ → SUB; SLT/SLTI → SLT; AND/ANDI → AND; ORI → OR.
- JAL: RegWre = 1, RegDst = 00, WrRegDSrc = 0, all in ID.
- RegWre = 1 only in WB_AL, WB_LD and ID-for-JAL.
- Destination register: RegDst = 10 for R-type, 01 for immediate forms and LW.
- Data memory: mWR = 1 only in MEM for SW. mRD = 1 in MEM and WB_LD for LW. DBDataSrc = 1 in WB_LD.
- Unknown opcode (feature off): treated as NOP. Path is IF → ID → IF, with PCWre = 1 in ID and PCSrc = 00.

Optional Feature:
- Macro: MC_CTRL_ILLEGAL_TRAP_EN.
- When defined: an unknown opcode in ID → HALT, and an extra output illegal_op (1 bit) goes to 1 and stays 1 until Reset.
- When undefined: unknown opcode is a NOP as above, and the illegal_op port is absent.

Decomposition:
- Package mc_ctrl_pkg: opcode localparams, state encoding (4-bit), PCSrc/RegDst/ALUOp codes.
- Sub-module mc_ctrl_decode: purely combinational; maps (state, opcode, zero, sign, Reset) to all control outputs.
- Top module: holds the state register and next-state logic.

Test Plan:
- Reset held 2 cycles mid-WB_AL → state = IF; PCWre, RegWre and mWR = 0 during reset; IRWre = 1 on the first cycle after release.
- ADDIU then ORI → 4 cycles each. ExtSel = 1 and 0 respectively, ALUSrcB = 1, RegDst = 01, RegWre = 1 only in WB_AL.
- LW → states IF, ID, EXE_LS, MEM, WB_LD. mRD = 1 in MEM and WB_LD, DBDataSrc = 1 in WB_LD. SW → 4 cycles, mWR = 1 only in MEM.
- BEQ with zero = 1 → PCSrc = 01 in EXE_BR. BNE with zero = 1 → PCSrc = 00. BLTZ with sign = 1 → PCSrc = 01. All take 3 cycles, RegWre = 0.
- JAL → 2 cycles. In ID: RegWre = 1, RegDst = 00, WrRegDSrc = 0, PCSrc = 11, PCWre = 1. JR → PCSrc = 10.
- HALT → state stays HALT for 10 cycles with PCWre = 0. Opcode 101010 → NOP (IF → ID → IF, PCWre = 1) with MC_CTRL_ILLEGAL_TRAP_EN off; → HALT with illegal_op = 1 with it on.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, states,
// datapath select codes and opcode classification helpers.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_ANDI  = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_SLT   = 6'b100110;
    localparam logic [5:0] OP_SLTI  = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EXE_AL = 4'd2,
        S_EXE_BR = 4'd3,
        S_EXE_LS = 4'd4,
        S_MEM    = 4'd5,
        S_WB_AL  = 4'd6,
        S_WB_LD  = 4'd7,
        S_HALT   = 4'd8
    } ctrlState_t;

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_RS     = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    localparam logic [1:0] RD_RA = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RD = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;

    typedef struct packed {
        logic       pcWre;
        logic       irWre;
        logic       insMemRW;
        logic       aluSrcA;
        logic       aluSrcB;
        logic       extSel;
        logic [1:0] regDst;
        logic       wrRegDSrc;
        logic       regWre;
        logic       mRD;
        logic       mWR;
        logic       dbDataSrc;
        logic [1:0] pcSrc;
        logic [2:0] aluOp;
    } ctrlSig_t;

    function automatic logic isJumpOp(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JR) || (op == OP_JAL);
    endfunction

    function automatic logic isBranchOp(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLTZ);
    endfunction

    function automatic logic isLdStOp(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    // Opcodes that take the EXE_AL / WB_AL path.
    function automatic logic isAluOp(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI,
            OP_ORI, OP_SLT, OP_SLTI: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic logic isKnownOp(input logic [5:0] op);
        return isAluOp(op) || isLdStOp(op) || isBranchOp(op) ||
               isJumpOp(op) || (op == OP_HALT);
    endfunction

    function automatic logic extSelFor(input logic [5:0] op);
        case (op)
            OP_ADDIU, OP_SLTI, OP_LW, OP_SW,
            OP_BEQ, OP_BNE, OP_BLTZ: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic logic aluSrcBFor(input logic [5:0] op);
        case (op)
            OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI, OP_LW, OP_SW: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] aluOpFor(input logic [5:0] op);
        case (op)
            OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ: return ALU_SUB;
            OP_SLT, OP_SLTI:                 return ALU_SLT;
            OP_AND, OP_ANDI:                 return ALU_AND;
            OP_ORI:                          return ALU_OR;
            default:                         return ALU_ADD;
        endcase
    endfunction

    function automatic logic [1:0] regDstFor(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_SLT:              return RD_RD;
            OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI, OP_LW:   return RD_RT;
            default:                                     return RD_RA;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control decode: (state, opcode, flags, Reset) -> datapath controls.
// With MC_CTRL_ILLEGAL_TRAP_EN defined, unknown opcodes do not advance the PC in ID.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  ctrlState_t  state,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        sign,
    input  logic        Reset,
    output ctrlSig_t    ctrl
);

    logic brTaken;

    assign brTaken = ((opcode == OP_BEQ)  &&  zero) ||
                     ((opcode == OP_BNE)  && !zero) ||
                     ((opcode == OP_BLTZ) &&  sign);

    always_comb begin
        ctrl = '0;
        if (Reset) begin
            ctrl.insMemRW = 1'b1;
        end else begin
            ctrl.insMemRW = (state == S_IF);
            ctrl.irWre    = (state == S_IF);
            // Operand/extender selects stay put from ID to the last cycle.
            if (state != S_IF && state != S_HALT) begin
                ctrl.extSel  = extSelFor(opcode);
                ctrl.aluSrcB = aluSrcBFor(opcode);
                ctrl.aluOp   = aluOpFor(opcode);
                ctrl.regDst  = regDstFor(opcode);
            end
            case (state)
                S_ID: begin
                    if (isJumpOp(opcode)) begin
                        ctrl.pcWre = 1'b1;
                        ctrl.pcSrc = (opcode == OP_JR) ? PC_RS : PC_JUMP;
                        if (opcode == OP_JAL) begin
                            ctrl.regWre    = 1'b1;
                            ctrl.regDst    = RD_RA;
                            ctrl.wrRegDSrc = 1'b0;
                        end
                    end else if (!isKnownOp(opcode)) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                        ctrl.pcWre = 1'b0;
`else
                        ctrl.pcWre = 1'b1;
`endif
                    end
                end
                S_EXE_BR: begin
                    ctrl.pcWre = 1'b1;
                    ctrl.pcSrc = brTaken ? PC_BRANCH : PC_NEXT;
                end
                S_MEM: begin
                    if (opcode == OP_LW) begin
                        ctrl.mRD = 1'b1;
                    end else begin
                        ctrl.mWR   = 1'b1;
                        ctrl.pcWre = 1'b1;
                    end
                end
                S_WB_AL: begin
                    ctrl.pcWre     = 1'b1;
                    ctrl.regWre    = 1'b1;
                    ctrl.wrRegDSrc = 1'b1;
                end
                S_WB_LD: begin
                    ctrl.pcWre     = 1'b1;
                    ctrl.regWre    = 1'b1;
                    ctrl.wrRegDSrc = 1'b1;
                    ctrl.mRD       = 1'b1;
                    ctrl.dbDataSrc = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit: state register, sequencing and output unpacking.
// Define MC_CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes into HALT and expose illegal_op.
module multicycle_control
    import mc_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       sign,
    output logic       PCWre,
    output logic       IRWre,
    output logic       InsMemRW,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic       ExtSel,
    output logic [1:0] RegDst,
    output logic       WrRegDSrc,
    output logic       RegWre,
    output logic       mRD,
    output logic       mWR,
    output logic       DBDataSrc,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUOp,
    output logic [3:0] state
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic       illegal_op
`endif
);

    ctrlState_t curState, nextState;
    ctrlSig_t   ctrl;

    always_ff @(posedge CLK) begin
        if (Reset) curState <= S_IF;
        else       curState <= nextState;
    end

    always_comb begin
        nextState = curState;
        case (curState)
            S_IF:     nextState = S_ID;
            S_ID: begin
                if (isJumpOp(opcode))        nextState = S_IF;
                else if (opcode == OP_HALT)  nextState = S_HALT;
                else if (isBranchOp(opcode)) nextState = S_EXE_BR;
                else if (isLdStOp(opcode))   nextState = S_EXE_LS;
                else if (isAluOp(opcode))    nextState = S_EXE_AL;
                else
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                                             nextState = S_HALT;
`else
                                             nextState = S_IF;
`endif
            end
            S_EXE_AL: nextState = S_WB_AL;
            S_EXE_BR: nextState = S_IF;
            S_EXE_LS: nextState = S_MEM;
            S_MEM:    nextState = (opcode == OP_LW) ? S_WB_LD : S_IF;
            S_WB_AL:  nextState = S_IF;
            S_WB_LD:  nextState = S_IF;
            S_HALT:   nextState = S_HALT;
            default:  nextState = S_IF;
        endcase
    end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    // Sticky until reset; set on the edge that leaves ID for HALT.
    always_ff @(posedge CLK) begin
        if (Reset)                                          illegal_op <= 1'b0;
        else if (curState == S_ID && !isKnownOp(opcode))    illegal_op <= 1'b1;
    end
`endif

    mc_ctrl_decode uDecode (
        .state  (curState),
        .opcode (opcode),
        .zero   (zero),
        .sign   (sign),
        .Reset  (Reset),
        .ctrl   (ctrl)
    );

    always_comb begin
        PCWre     = ctrl.pcWre;
        IRWre     = ctrl.irWre;
        InsMemRW  = ctrl.insMemRW;
        ALUSrcA   = ctrl.aluSrcA;
        ALUSrcB   = ctrl.aluSrcB;
        ExtSel    = ctrl.extSel;
        RegDst    = ctrl.regDst;
        WrRegDSrc = ctrl.wrRegDSrc;
        RegWre    = ctrl.regWre;
        mRD       = ctrl.mRD;
        mWR       = ctrl.mWR;
        DBDataSrc = ctrl.dbDataSrc;
        PCSrc     = ctrl.pcSrc;
        ALUOp     = ctrl.aluOp;
        state     = curState;
    end

endmodule
